// File: rtl/gpa_fhdo_iface_pkg.sv
// Shared constants, states and frame builders for the GPA-FHDO SPI initiator.
package gpa_fhdo_iface_pkg;

    localparam logic [7:0]  DacRegBase  = 8'h08;
    localparam logic [15:0] AdcManBase  = 16'hC000;
    localparam int unsigned DacFrameLen = 24;
    localparam int unsigned AdcFrameLen = 32;
    localparam logic [4:0]  DacLastBit  = 5'(DacFrameLen - 1);
    localparam logic [4:0]  AdcLastBit  = 5'(AdcFrameLen - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDacXfer,
        StAdcPre,
        StAdcXfer,
        StGap
    } state_e;

    typedef enum logic [1:0] {
        PhLead,
        PhHigh,
        PhLow
    } phase_e;

    // Frames are left-aligned in a 32-bit shift register, MSB first.
    function automatic logic [31:0] dac_word(input logic [1:0] ch, input logic [15:0] data);
        return {DacRegBase + {6'd0, ch}, data, 8'h00};
    endfunction

    function automatic logic [31:0] adc_word(input logic [1:0] ch);
        return {AdcManBase | {4'd0, ch, 10'd0}, 16'h0000};
    endfunction

endpackage

// File: rtl/gpa_fhdo_iface_if.sv
// Request/response bus between the gradient sequencer and the GPA-FHDO SPI initiator.
interface gpa_fhdo_iface_if;
    logic [15:0] dac_data_i;
    logic [1:0]  dac_ch_i;
    logic        dac_valid_i;
    logic [1:0]  adc_ch_i;
    logic        adc_valid_i;
    logic        ready_o;
    logic [15:0] adc_data_o;
    logic        adc_data_valid_o;

    modport master (
        output dac_data_i, dac_ch_i, dac_valid_i, adc_ch_i, adc_valid_i,
        input  ready_o, adc_data_o, adc_data_valid_o
    );

    modport slave (
        input  dac_data_i, dac_ch_i, dac_valid_i, adc_ch_i, adc_valid_i,
        output ready_o, adc_data_o, adc_data_valid_o
    );
endinterface

// File: rtl/gpa_fhdo_spi_shifter.sv
// SPI bit engine: SCLK divider, 32-bit MSB-first shift-out, 16-bit shift-in, done strobe.
module gpa_fhdo_spi_shifter
    import gpa_fhdo_iface_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] word,
    input  logic [4:0]  last_bit,
    input  logic        sdi,
    output logic        done,
    output logic        sclk,
    output logic        sdo,
    output logic [15:0] rx_data
);

    localparam int unsigned DivW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCLK_DIV - 1);

    logic            busy_q, busy_d;
    phase_e          phase_q, phase_d;
    logic [DivW-1:0] div_q, div_d;
    logic [4:0]      bit_q, bit_d;
    logic [4:0]      last_q, last_d;
    logic [31:0]     sr_q, sr_d;
    logic [15:0]     rx_q, rx_d;
    logic            sclk_q, sclk_d;
    logic            sdo_q, sdo_d;
    logic            rise;

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        div_d   = div_q;
        bit_d   = bit_q;
        last_d  = last_q;
        sr_d    = sr_q;
        rx_d    = rx_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        done    = 1'b0;
        rise    = 1'b0;
        if (start) begin
            busy_d  = 1'b1;
            phase_d = PhLead;
            div_d   = DivLast;
            bit_d   = 5'd0;
            last_d  = last_bit;
            sr_d    = word;
            sclk_d  = 1'b0;
            sdo_d   = 1'b0;
        end else if (busy_q) begin
            if (div_q != '0) begin
                div_d = div_q - DivW'(1);
            end else begin
                div_d = DivLast;
                unique case (phase_q)
                    PhLead: rise = 1'b1;
                    PhHigh: begin
                        phase_d = PhLow;
                        sclk_d  = 1'b0;
                    end
                    default: begin
                        // Frame ends on terminal count; the counter never wraps.
                        if (bit_q == last_q) begin
                            busy_d = 1'b0;
                            sdo_d  = 1'b0;
                            done   = 1'b1;
                        end else begin
                            bit_d = bit_q + 5'd1;
                            rise  = 1'b1;
                        end
                    end
                endcase
                if (rise) begin
                    phase_d = PhHigh;
                    sclk_d  = 1'b1;
                    sdo_d   = sr_q[31];
                    sr_d    = {sr_q[30:0], 1'b0};
                    // Only the data half of an ADC frame carries a result.
                    if (bit_d[4] && last_q == AdcLastBit) begin
                        rx_d = {rx_q[14:0], sdi};
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            phase_q <= PhLead;
            div_q   <= '0;
            bit_q   <= 5'd0;
            last_q  <= 5'd0;
            sr_q    <= 32'd0;
            rx_q    <= 16'd0;
            sclk_q  <= 1'b0;
            sdo_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            last_q  <= last_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            sclk_q  <= sclk_d;
            sdo_q   <= sdo_d;
        end
    end

    assign sclk    = sclk_q;
    assign sdo     = sdo_q;
    assign rx_data = rx_q;

endmodule

// File: rtl/gpa_fhdo_iface.sv
// GPA-FHDO SPI initiator: DAC80504 writes, ADS8684 readback when GPA_FHDO_IFACE_ADC_EN is defined.
module gpa_fhdo_iface
    import gpa_fhdo_iface_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic            clk,
    input  logic            rst,
    gpa_fhdo_iface_if.slave bus,
    output logic            spi_clk,
    output logic            spi_csn,
    output logic            spi_sdo,
    input  logic            spi_sdi
);

    localparam int unsigned GapW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GapW-1:0] GapLast = GapW'(CS_GAP - 1);

    state_e          state_q, state_d;
    logic [GapW-1:0] gap_q, gap_d;
    logic            gap_csn_q, gap_csn_d;
    logic            sh_start, sh_done, sh_sdi;
    logic [31:0]     sh_word;
    logic [4:0]      sh_last;
    logic [15:0]     sh_rx;

`ifdef GPA_FHDO_IFACE_ADC_EN
    logic [1:0]  adc_ch_q, adc_ch_d;
    logic [15:0] adc_data_q, adc_data_d;
    logic        adc_dv_q, adc_dv_d;
    assign sh_sdi = spi_sdi;
`else
    logic unused_adc;
    assign unused_adc = ^{bus.adc_ch_i, bus.adc_valid_i, spi_sdi, sh_rx};
    assign sh_sdi     = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        gap_d     = gap_q;
        gap_csn_d = gap_csn_q;
        sh_start  = 1'b0;
        sh_word   = dac_word(bus.dac_ch_i, bus.dac_data_i);
        sh_last   = DacLastBit;
`ifdef GPA_FHDO_IFACE_ADC_EN
        adc_ch_d   = adc_ch_q;
        adc_data_d = adc_data_q;
        adc_dv_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.dac_valid_i) begin
                    state_d  = StDacXfer;
                    sh_start = 1'b1;
`ifdef GPA_FHDO_IFACE_ADC_EN
                end else if (bus.adc_valid_i) begin
                    state_d  = StAdcPre;
                    adc_ch_d = bus.adc_ch_i;
                    gap_d    = GapLast;
`endif
                end
            end
            StDacXfer: begin
                if (sh_done) begin
                    state_d   = StGap;
                    gap_d     = GapLast;
                    gap_csn_d = 1'b1;
                end
            end
`ifdef GPA_FHDO_IFACE_ADC_EN
            // Zero-clock DAC select so the DAC discards it, then the ADC frame proper.
            StAdcPre: begin
                if (gap_q == '0) begin
                    state_d  = StAdcXfer;
                    sh_start = 1'b1;
                    sh_word  = adc_word(adc_ch_q);
                    sh_last  = AdcLastBit;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            StAdcXfer: begin
                if (sh_done) begin
                    state_d    = StGap;
                    gap_d      = GapLast;
                    gap_csn_d  = 1'b0;
                    adc_data_d = sh_rx;
                    adc_dv_d   = 1'b1;
                end
            end
`endif
            StGap: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - GapW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            gap_q     <= '0;
            gap_csn_q <= 1'b1;
`ifdef GPA_FHDO_IFACE_ADC_EN
            adc_ch_q   <= 2'd0;
            adc_data_q <= 16'd0;
            adc_dv_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gap_q     <= gap_d;
            gap_csn_q <= gap_csn_d;
`ifdef GPA_FHDO_IFACE_ADC_EN
            adc_ch_q   <= adc_ch_d;
            adc_data_q <= adc_data_d;
            adc_dv_q   <= adc_dv_d;
`endif
        end
    end

    // csn=0 selects the DAC, csn=1 the ADC; idle high.
    always_comb begin
        unique case (state_q)
            StDacXfer, StAdcPre: spi_csn = 1'b0;
            StGap:               spi_csn = gap_csn_q;
            default:             spi_csn = 1'b1;
        endcase
    end

    assign bus.ready_o = (state_q == StIdle);

`ifdef GPA_FHDO_IFACE_ADC_EN
    assign bus.adc_data_o       = adc_data_q;
    assign bus.adc_data_valid_o = adc_dv_q;
`else
    assign bus.adc_data_o       = 16'd0;
    assign bus.adc_data_valid_o = 1'b0;
`endif

    gpa_fhdo_spi_shifter #(
        .SCLK_DIV(SCLK_DIV)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .start    (sh_start),
        .word     (sh_word),
        .last_bit (sh_last),
        .sdi      (sh_sdi),
        .done     (sh_done),
        .sclk     (spi_clk),
        .sdo      (spi_sdo),
        .rx_data  (sh_rx)
    );

endmodule
